// File: rtl/overlay_fb_writer_if.sv
// Bundle of the overlay-stream handshakes and the frame-buffer write port.
// The slave modport is the writer's view; the master modport is the generator/memory side.
interface overlay_fb_writer_if;
    logic        start;
    logic        start_ack;
    logic        done;
    logic        done_ack;
    logic [53:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wvalid;
    logic        mem_wready;

    modport slave (
        input  start_ack,
        input  done,
        input  din,
        input  din_valid,
        input  mem_wready,
        output start,
        output done_ack,
        output din_ready,
        output mem_addr,
        output mem_wdata,
        output mem_wmask,
        output mem_wvalid
    );

    modport master (
        output start_ack,
        output done,
        output din,
        output din_valid,
        output mem_wready,
        input  start,
        input  done_ack,
        input  din_ready,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wmask,
        input  mem_wvalid
    );
endinterface

// File: rtl/overlay_fb_writer.sv
// Overlay stream consumer: requests a frame, filters and buffers incoming words in a
// first-word-fall-through FIFO, and issues masked writes to the frame-buffer port.
module overlay_fb_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_ADDR   = 63304,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    overlay_fb_writer_if.slave   bus,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     word_count,
    output logic                 frame_err,
    output logic                 addr_err
);

    localparam int                AW         = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]       DEPTH_C    = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       CNT_ONE_C  = (AW+1)'(1);
    localparam logic [AW-1:0]     PTR_ONE_C  = AW'(1);
    localparam logic [16:0]       MAX_ADDR_C = 17'(MAX_ADDR);
    localparam logic [CNT_W-1:0]  WC_MAX_C   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  WC_ONE_C   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        ACK    = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [17:0] addr;
        logic [31:0] data;
    } entry_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic               done_ack_q, done_ack_d;
    logic               frame_done_q, frame_done_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;
    logic               frame_err_q, frame_err_d;
    logic               addr_err_q, addr_err_d;
    logic               first_seen_q, first_seen_d;
    logic               cur_frame_q, cur_frame_d;

    entry_t             fifo_mem_q [FIFO_DEPTH];
    entry_t             fifo_mem_d [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;

    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               din_ready_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               addr_bad_s;
    logic [3:0]         in_mask_s;
    logic               in_frame_s;
    logic [16:0]        in_addr_s;
    logic [31:0]        in_pixel_s;
    logic               frame_entry_s;
    entry_t             head_s;

    // Input word decode, handshake qualification and filtering.
    always_comb begin
        in_mask_s    = bus.din[53:50];
        in_frame_s   = bus.din[49];
        in_addr_s    = bus.din[48:32];
        in_pixel_s   = bus.din[31:0];
        fifo_full_s  = (count_q == DEPTH_C);
        fifo_empty_s = (count_q == {(AW+1){1'b0}});
        din_ready_s  = (state_q == STREAM) && !fifo_full_s;
        accept_s     = din_ready_s && bus.din_valid;
        addr_bad_s   = (in_addr_s > MAX_ADDR_C);
        push_s       = accept_s && !addr_bad_s && (in_mask_s != 4'd0);
        pop_s        = !fifo_empty_s && bus.mem_wready;
        head_s       = fifo_mem_q[rd_ptr_q];
    end

    // Frame sequencing FSM next state and registered handshake outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.start_ack) begin
                    state_d = STREAM;
                end else begin
                    state_d = REQ;
                end
            end
            STREAM: begin
                if (bus.done) begin
                    state_d = DRAIN;
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                // An empty FIFO also means no write is outstanding on the memory port.
                if (fifo_empty_s) begin
                    state_d = ACK;
                end else begin
                    state_d = DRAIN;
                end
            end
            ACK: begin
                if (!bus.done) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d       = (state_d == REQ);
        done_ack_d    = (state_d == ACK);
        frame_done_d  = (state_q == ACK) && !bus.done;
        frame_entry_s = (state_q == IDLE) && (state_d == REQ);
    end

    // Per-frame bookkeeping: written-word counter, frame tracking and sticky errors.
    always_comb begin
        word_count_d = word_count_q;
        first_seen_d = first_seen_q;
        cur_frame_d  = cur_frame_q;
        frame_err_d  = frame_err_q;
        addr_err_d   = addr_err_q;

        if (frame_entry_s) begin
            word_count_d = {CNT_W{1'b0}};
            first_seen_d = 1'b0;
        end else begin
            if (pop_s && (word_count_q != WC_MAX_C)) begin
                word_count_d = word_count_q + WC_ONE_C;
            end else begin
                word_count_d = word_count_q;
            end
            if (accept_s) begin
                first_seen_d = 1'b1;
            end else begin
                first_seen_d = first_seen_q;
            end
        end

        // The frame check covers every accepted word, including ones later filtered out.
        if (accept_s && !first_seen_q) begin
            cur_frame_d = in_frame_s;
        end else if (accept_s && (in_frame_s != cur_frame_q)) begin
            frame_err_d = 1'b1;
        end else begin
            cur_frame_d = cur_frame_q;
        end

        if (accept_s && addr_bad_s) begin
            addr_err_d = 1'b1;
        end else begin
            addr_err_d = addr_err_q;
        end
    end

    // FIFO pointer, occupancy and storage update.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (push_s) begin
            fifo_mem_d[wr_ptr_q] = '{mask: in_mask_s, addr: {in_frame_s, in_addr_s}, data: in_pixel_s};
            wr_ptr_d             = wr_ptr_q + PTR_ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            done_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            word_count_q <= {CNT_W{1'b0}};
            frame_err_q  <= 1'b0;
            addr_err_q   <= 1'b0;
            first_seen_q <= 1'b0;
            cur_frame_q  <= 1'b0;
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {(AW+1){1'b0}};
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            done_ack_q   <= done_ack_d;
            frame_done_q <= frame_done_d;
            word_count_q <= word_count_d;
            frame_err_q  <= frame_err_d;
            addr_err_q   <= addr_err_d;
            first_seen_q <= first_seen_d;
            cur_frame_q  <= cur_frame_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO data storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clock) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign bus.start      = start_q;
    assign bus.done_ack   = done_ack_q;
    assign bus.din_ready  = din_ready_s;
    assign bus.mem_wvalid = !fifo_empty_s;
    assign bus.mem_addr   = head_s.addr;
    assign bus.mem_wdata  = head_s.data;
    assign bus.mem_wmask  = head_s.mask;
    assign frame_done     = frame_done_q;
    assign word_count     = word_count_q;
    assign frame_err      = frame_err_q;
    assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_overlay_fb_writer.sv
// Directed bench for overlay_fb_writer: plays the overlay generator and the frame-buffer
// memory, and checks every write against hand-computed expectations.
module tb_overlay_fb_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_done;
    logic [15:0] word_count;
    logic        frame_err;
    logic        addr_err;

    overlay_fb_writer_if bif ();

    overlay_fb_writer #(
        .FIFO_DEPTH (4),
        .MAX_ADDR   (63304),
        .CNT_W      (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .bus        (bif),
        .frame_done (frame_done),
        .word_count (word_count),
        .frame_err  (frame_err),
        .addr_err   (addr_err)
    );

    always #5 clock = ~clock;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          fd_cnt   = 0;
    logic [53:0] wr_q [$];

    // Memory-side log of completed writes {mask, addr, data} and frame_done pulses.
    always @(posedge clock) begin
        if (!reset && bif.mem_wvalid && bif.mem_wready) begin
            wr_q.push_back({bif.mem_wmask, bif.mem_addr, bif.mem_wdata});
        end
        if (!reset && frame_done) begin
            fd_cnt <= fd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [3:0] m, input logic f,
                          input logic [16:0] a, input logic [31:0] p);
        logic [53:0] got;
        got = (idx < wr_q.size()) ? wr_q[idx] : 54'h0;
        chk(tag, 64'(got), 64'({m, f, a, p}));
    endtask

    task automatic send_word(input logic [3:0] m, input logic f, input logic [16:0] a, input logic [31:0] p);
        logic ok;
        logic got;
        bif.din       = {m, f, a, p};
        bif.din_valid = 1'b1;
        got           = 1'b0;
        for (int k = 0; k < 100; k++) begin
            ok = bif.din_ready;
            tick();
            if (ok) begin
                got = 1'b1;
                break;
            end
        end
        bif.din_valid = 1'b0;
        if (!got) chk("accept_timeout", 64'(got), 64'd1);
    endtask

    task automatic start_frame();
        logic got;
        enable = 1'b1;
        got    = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (bif.start) begin
                got = 1'b1;
                break;
            end
        end
        chk("start_seen", 64'(got), 64'd1);
        bif.start_ack = 1'b1;
        tick();
        bif.start_ack = 1'b0;
        enable        = 1'b0;
        chk("start_drop", 64'(bif.start), 64'd0);
        chk("stream_ready", 64'(bif.din_ready), 64'd1);
        chk("wc_cleared", 64'(word_count), 64'd0);
    endtask

    task automatic end_frame(input int n_exp, input int base, input int fd_base);
        logic got;
        bif.din_valid = 1'b0;
        bif.done      = 1'b1;
        got           = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bif.done_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_ack_rise", 64'(got), 64'd1);
        chk("writes_before_ack", 64'(wr_q.size() - base), 64'(n_exp));
        chk("fifo_empty_at_ack", 64'(bif.mem_wvalid), 64'd0);
        bif.done = 1'b0;
        tick();
        chk("frame_done_hi", 64'(frame_done), 64'd1);
        chk("done_ack_fall", 64'(bif.done_ack), 64'd0);
        tick();
        chk("frame_done_lo", 64'(frame_done), 64'd0);
        chk("frame_done_once", 64'(fd_cnt - fd_base), 64'd1);
        chk("word_count", 64'(word_count), 64'(n_exp));
    endtask

    initial begin
        int  base;
        int  fdb;
        logic ok;

        reset          = 1'b1;
        enable         = 1'b0;
        bif.start_ack  = 1'b0;
        bif.done       = 1'b0;
        bif.din        = 54'h0;
        bif.din_valid  = 1'b0;
        bif.mem_wready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_start", 64'(bif.start), 64'd0);
        chk("rst_done_ack", 64'(bif.done_ack), 64'd0);
        chk("rst_din_ready", 64'(bif.din_ready), 64'd0);
        chk("rst_wvalid", 64'(bif.mem_wvalid), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_wc", 64'(word_count), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_addr_err", 64'(addr_err), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_no_start", 64'(bif.start), 64'd0);

        // Basic 64-word frame at full rate, frame bit 1
        base = wr_q.size();
        fdb  = fd_cnt;
        bif.mem_wready = 1'b1;
        start_frame();
        for (int i = 0; i < 64; i++) send_word(4'hF, 1'b1, 17'(60100 + i), 32'hA500_0000 + 32'(i));
        end_frame(64, base, fdb);
        for (int i = 0; i < 64; i++) chk_wr("basic_wr", base + i, 4'hF, 1'b1, 17'(60100 + i), 32'hA500_0000 + 32'(i));
        chk("basic_frame_err", 64'(frame_err), 64'd0);
        chk("basic_addr_err", 64'(addr_err), 64'd0);

        // Backpressure: four words fill the FIFO, port held stable for 10 cycles
        base = wr_q.size();
        fdb  = fd_cnt;
        bif.mem_wready = 1'b0;
        start_frame();
        chk("bp_empty", 64'(bif.mem_wvalid), 64'd0);
        send_word(4'hF, 1'b0, 17'd10, 32'h1111_0000);
        chk("bp_latency_valid", 64'(bif.mem_wvalid), 64'd1);
        chk("bp_latency_addr", 64'(bif.mem_addr), 64'd10);
        for (int i = 1; i < 4; i++) send_word(4'hF, 1'b0, 17'(10 + i), 32'h1111_0000 + 32'(i));
        chk("bp_full_ready", 64'(bif.din_ready), 64'd0);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!(bif.mem_wvalid && !bif.din_ready && bif.mem_addr == 18'd10 &&
                  bif.mem_wdata == 32'h1111_0000 && bif.mem_wmask == 4'hF)) ok = 1'b0;
        end
        chk("bp_stable", 64'(ok), 64'd1);
        chk("bp_no_write", 64'(wr_q.size() - base), 64'd0);
        bif.mem_wready = 1'b1;
        send_word(4'hF, 1'b0, 17'd14, 32'h1111_0004);
        send_word(4'hF, 1'b0, 17'd15, 32'h1111_0005);
        end_frame(6, base, fdb);
        for (int i = 0; i < 6; i++) chk_wr("bp_wr", base + i, 4'hF, 1'b0, 17'(10 + i), 32'h1111_0000 + 32'(i));

        // Filtering: out-of-range address and empty mask are dropped
        base = wr_q.size();
        fdb  = fd_cnt;
        start_frame();
        send_word(4'h3, 1'b0, 17'd100, 32'h2222_0000);
        chk("flt_addr_err_pre", 64'(addr_err), 64'd0);
        send_word(4'hF, 1'b0, 17'd63305, 32'h2222_0001);
        chk("flt_addr_err_set", 64'(addr_err), 64'd1);
        send_word(4'h0, 1'b0, 17'd101, 32'h2222_0002);
        send_word(4'h8, 1'b0, 17'd63304, 32'h2222_0003);
        send_word(4'hF, 1'b0, 17'd102, 32'h2222_0004);
        end_frame(3, base, fdb);
        chk_wr("flt_wr0", base + 0, 4'h3, 1'b0, 17'd100, 32'h2222_0000);
        chk_wr("flt_wr1", base + 1, 4'h8, 1'b0, 17'd63304, 32'h2222_0003);
        chk_wr("flt_wr2", base + 2, 4'hF, 1'b0, 17'd102, 32'h2222_0004);
        chk("flt_frame_err", 64'(frame_err), 64'd0);

        // Frame mismatch on the fifth word
        base = wr_q.size();
        fdb  = fd_cnt;
        start_frame();
        for (int i = 0; i < 4; i++) send_word(4'hF, 1'b1, 17'(200 + i), 32'h3333_0000 + 32'(i));
        chk("fm_err_pre", 64'(frame_err), 64'd0);
        send_word(4'hF, 1'b0, 17'd204, 32'h3333_0004);
        chk("fm_err_set", 64'(frame_err), 64'd1);
        end_frame(5, base, fdb);
        for (int i = 0; i < 4; i++) chk_wr("fm_wr", base + i, 4'hF, 1'b1, 17'(200 + i), 32'h3333_0000 + 32'(i));
        chk_wr("fm_wr_mismatch", base + 4, 4'hF, 1'b0, 17'd204, 32'h3333_0004);

        // done while the FIFO holds four words
        base = wr_q.size();
        fdb  = fd_cnt;
        bif.mem_wready = 1'b0;
        start_frame();
        for (int i = 0; i < 4; i++) send_word(4'hF, 1'b1, 17'(300 + i), 32'h4444_0000 + 32'(i));
        chk("df_full", 64'(bif.din_ready), 64'd0);
        bif.done = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bif.done_ack) ok = 1'b0;
        end
        chk("df_ack_held_low", 64'(ok), 64'd1);
        bif.mem_wready = 1'b1;
        end_frame(4, base, fdb);
        for (int i = 0; i < 4; i++) chk_wr("df_wr", base + i, 4'hF, 1'b1, 17'(300 + i), 32'h4444_0000 + 32'(i));

        // Reset mid-stream with three words buffered
        bif.mem_wready = 1'b0;
        start_frame();
        for (int i = 0; i < 4; i++) send_word(4'hF, 1'b0, 17'(400 + i), 32'h5555_0000 + 32'(i));
        bif.mem_wready = 1'b1;
        tick();
        bif.mem_wready = 1'b0;
        chk("rm_wc_before", 64'(word_count), 64'd1);
        chk("rm_wvalid_before", 64'(bif.mem_wvalid), 64'd1);
        reset = 1'b1;
        tick();
        chk("rm_wvalid", 64'(bif.mem_wvalid), 64'd0);
        chk("rm_start", 64'(bif.start), 64'd0);
        chk("rm_wc", 64'(word_count), 64'd0);
        chk("rm_frame_err", 64'(frame_err), 64'd0);
        chk("rm_addr_err", 64'(addr_err), 64'd0);
        chk("rm_din_ready", 64'(bif.din_ready), 64'd0);
        reset = 1'b0;
        base = wr_q.size();
        fdb  = fd_cnt;
        bif.mem_wready = 1'b1;
        start_frame();
        send_word(4'hF, 1'b1, 17'd500, 32'h6666_0000);
        send_word(4'h5, 1'b1, 17'd501, 32'h6666_0001);
        end_frame(2, base, fdb);
        chk_wr("rm_wr0", base + 0, 4'hF, 1'b1, 17'd500, 32'h6666_0000);
        chk_wr("rm_wr1", base + 1, 4'h5, 1'b1, 17'd501, 32'h6666_0001);
        chk("rm_final_errs", 64'({frame_err, addr_err}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/overlay_fb_writer.md
Name: overlay_fb_writer

Overview:
- Consumer end of the overlay stream: requests a frame from the overlay generator via start/start_ack and accepts 54-bit words {mask[3:0], frame, addr[16:0], pixel[31:0]} on a valid/ready interface.
- Buffers accepted words in a small FIFO and issues masked 32-bit writes to the double-buffered frame-buffer write port.
- Closes each frame with the done/done_ack handshake and a one-cycle frame_done pulse toward the display swap logic.

Parameters:
- FIFO_DEPTH, 4, number of buffered words; power of two, minimum 2.
- MAX_ADDR, 63304, highest legal 17-bit word address; words above it are dropped.
- CNT_W, 16, width of the per-frame written-word counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  level; while high, a new frame request is issued from IDLE
- start  out  1  frame request to the generator
- start_ack  in  1  generator acknowledge
- done  in  1  generator end-of-frame flag
- done_ack  out  1  end-of-frame acknowledge
- din  in  54  {mask[53:50], frame[49], addr[48:32], pixel[31:0]}
- din_valid  in  1  din is valid
- din_ready  out  1  writer accepts din this cycle
- mem_addr  out  18  {frame, addr}
- mem_wdata  out  32  pixel data
- mem_wmask  out  4  byte enables; bit n enables pixel[8n+7:8n]
- mem_wvalid  out  1  write request
- mem_wready  in  1  memory accepts the write
- frame_done  out  1  one-cycle pulse when a frame is fully written
- word_count  out  CNT_W  words written in the current or last frame
- frame_err  out  1  sticky; frame bit changed within a frame
- addr_err  out  1  sticky; a word with addr > MAX_ADDR was received

Behaviour:
- Reset values: start=0, done_ack=0, din_ready=0, mem_wvalid=0, frame_done=0, word_count=0, frame_err=0, addr_err=0. The FIFO is emptied and the FSM goes to IDLE. Reset mid-frame abandons all buffered words; no write is issued on the cycle after reset.
- FSM states: IDLE, REQ, STREAM, DRAIN, ACK.
- IDLE: if enable=1, go to REQ next cycle. word_count is cleared on entry to REQ.
- REQ: start=1 (registered). When start_ack=1 is sampled, start<=0 and go to STREAM.
- STREAM:
  - din_ready = !fifo_full (combinational from registered state).
  - A word is accepted when din_valid & din_ready.
  - The first accepted word latches its frame bit as cur_frame. A later accepted word with frame!=cur_frame sets frame_err; the word is still written.
  - Accepted words with addr > MAX_ADDR set addr_err and are not pushed.
  - Accepted words with mask==0 are discarded silently.
  - When done=1 is sampled, go to DRAIN. A word accepted in the same cycle as done is still processed.
- DRAIN: din_ready=0. When the FIFO is empty and no write is pending, go to ACK.
- ACK: done_ack=1. When done=0 is sampled, set done_ack<=0, pulse frame_done for 1 cycle, and go to IDLE.
- FIFO:
  - Push and pop may occur in the same cycle; occupancy is then unchanged.
  - A push is never attempted when full, because din_ready blocks it.
  - First-word fall-through: mem_wvalid = !fifo_empty; mem_addr, mem_wdata and mem_wmask come from the FIFO head.
  - Pop occurs on mem_wvalid & mem_wready. Output fields stay stable while mem_wvalid=1 and mem_wready=0.
- Latency: a word accepted at cycle N is presented on the memory port at cycle N+1 at the earliest.
- word_count: increments on each completed memory write (mem_wvalid & mem_wready) and saturates at all-ones. It holds its value in IDLE.
- Sticky errors clear only on reset.
- start_ack or done arriving in unexpected states is ignored.
- enable dropping mid-frame has no effect; the current frame completes.

Test Plan:
- Basic frame: enable=1, generator sends 64 words with mask=F and addr 60100..60163, mem_wready=1 → 64 writes with mem_addr={frame,addr} in order, word_count=64, done_ack asserted, exactly one frame_done pulse, no errors.
- Backpressure: mem_wready=0 for 10 cycles with FIFO_DEPTH=4 → din_ready drops after 4 accepts, no word is lost or duplicated, and the mem port holds stable until mem_wready=1.
- Filtering: words with addr=63305 and with mask=0 are interleaved → addr_err=1, frame_err=0, and neither word appears on the mem port; word_count excludes both.
- Frame mismatch: first word frame=1, fifth word frame=0 → frame_err=1 from the cycle after acceptance; all words are written, the fifth at mem_addr[17]=0.
- done with a full FIFO: done asserted while 4 words are buffered → done_ack is held low until all 4 writes complete, then goes high; it falls the cycle after done is sampled low, and frame_done pulses.
- Reset mid-stream: reset asserted with 3 words buffered → the next cycle shows mem_wvalid=0, start=0, word_count=0, errors cleared; a new frame with enable=1 completes normally.
